// File: rtl/pq_drain_if.sv
// Output-side valid/ready stream carrying values popped from the priority queue.
// The master drives data/valid and the slave drives ready.
interface pq_drain_if #(
   parameter int W = 8
);
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pq_drain.sv
// Drains the priority queue into a small output FIFO.
// Tracks count, running sum and a sticky ordering-error flag per drain.
module pq_drain #(
   parameter int W      = 8,
   parameter int DEPTH  = 6,
   parameter int FDEPTH = 4
) (
   input  logic           ck,
   input  logic           r,
   input  logic           start,
   input  logic [W-1:0]   top,
   output logic           shiftOut,
   pq_drain_if.master     dout,
   output logic           busy,
   output logic           done,
   output logic [2:0]     count,
   output logic [W+2:0]   sum,
   output logic           order_err
);

   localparam int PW = $clog2(FDEPTH);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  mem_q [FDEPTH];
   logic [W-1:0]  mem_d [FDEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   occ_q, occ_d;
   logic [2:0]    count_q, count_d;
   logic [W+2:0]  sum_q, sum_d;
   logic          err_q, err_d;
   logic [W-1:0]  prev_q, prev_d;

   logic fifo_full;
   logic fifo_rd;
   logic pop;

   // A pop may proceed into a full FIFO when the head is read in the same cycle.
   always_comb begin
      fifo_full = (occ_q == (PW+1)'(FDEPTH));
      fifo_rd   = (occ_q != '0) && dout.out_ready;
      pop       = (state_q == DRAIN) && (top != '0) &&
                  (count_q < 3'(DEPTH)) && (!fifo_full || fifo_rd);
   end

   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      count_d  = count_q;
      sum_d    = sum_q;
      err_d    = err_q;
      prev_d   = prev_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRAIN;
               count_d = '0;
               sum_d   = '0;
               err_d   = 1'b0;
               prev_d  = '1;
            end
         end
         DRAIN: begin
            if (pop) begin
               count_d = count_q + 3'd1;
               sum_d   = sum_q + (W+3)'(top);
               prev_d  = top;
               if (top > prev_q) begin
                  err_d = 1'b1;
               end
            end
            // Exit uses the post-pop count so no pop is issued beyond DEPTH.
            if ((top == '0) || (count_d == 3'(DEPTH))) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (occ_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (pop) begin
         mem_d[wr_ptr_q] = top;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (fifo_rd) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + {{PW{1'b0}}, pop} - {{PW{1'b0}}, fifo_rd};
   end

   always_ff @(posedge ck or posedge r) begin
      if (r) begin
         state_q  <= IDLE;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         count_q  <= '0;
         sum_q    <= '0;
         err_q    <= 1'b0;
         prev_q   <= '1;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         count_q  <= count_d;
         sum_q    <= sum_d;
         err_q    <= err_d;
         prev_q   <= prev_d;
      end
   end

   assign shiftOut       = pop;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign count          = count_q;
   assign sum            = sum_q;
   assign order_err      = err_q;
   assign dout.out_valid = (occ_q != '0);
   assign dout.out_data  = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
